// File: rtl/quad_decoder_sfr.sv
// Quadrature step decoder: sync, debounce, Gray phase tracking and
// detent division into incr/decr pulses for the up/down counter SFR.

module quad_sync_stage (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

module quad_db_stage #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic primed,
  input  logic sync,
  output logic deb
);
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (!primed) begin
      cnt <= '0;
      deb <= sync;
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt <= '0;
      deb <= sync;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

module quad_decoder_sfr #(
  parameter int DB_CYCLES = 4,
  parameter int DIV       = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic       a_in,
  input  logic       b_in,
  output logic       incr,
  output logic       decr,
  output logic       err,
  output logic [1:0] phase
);
  localparam logic signed [3:0] ACC_MAX = 4'(DIV - 1);
  localparam logic signed [3:0] ACC_MIN = 4'(1 - DIV);

  logic              a_s;
  logic              b_s;
  logic              a_d;
  logic              b_d;
  logic [1:0]        prime_cnt;
  logic              primed;
  logic [1:0]        prev;
  logic signed [3:0] acc;
  logic signed [3:0] acc_n;
  logic              incr_n;
  logic              decr_n;
  logic              err_n;
  logic [1:0]        diff;
  logic              eval;
  logic              fwd;
  logic              rev;
  logic              jump;

  function automatic logic [1:0] gray_pos(
    input logic [1:0] g
  );
    return {g[1], g[1] ^ g[0]};
  endfunction

  quad_sync_stage u_sync_a (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (a_in),
    .q     (a_s)
  );

  quad_sync_stage u_sync_b (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (b_in),
    .q     (b_s)
  );

  quad_db_stage #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk    (clk),
    .clr_n  (clr_n),
    .primed (primed),
    .sync   (a_s),
    .deb    (a_d)
  );

  quad_db_stage #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk    (clk),
    .clr_n  (clr_n),
    .primed (primed),
    .sync   (b_s),
    .deb    (b_d)
  );

  assign phase = {a_d, b_d};

  // Position difference on the Gray circle: 1 fwd, 3 rev, 2 jump.
  assign diff = gray_pos(phase) - gray_pos(prev);
  assign eval = primed && (phase != prev);
  assign fwd  = eval && (diff == 2'd1);
  assign rev  = eval && (diff == 2'd3);
  assign jump = eval && (diff == 2'd2);

  always_comb begin
    acc_n  = acc;
    incr_n = 1'b0;
    decr_n = 1'b0;
    err_n  = 1'b0;
    unique case (1'b1)
      jump: begin
        err_n = 1'b1;
        acc_n = '0;
      end
      fwd && en: begin
        if (acc == ACC_MAX) begin
          incr_n = 1'b1;
          acc_n  = '0;
        end else begin
          acc_n = acc + 4'sd1;
        end
      end
      rev && en: begin
        if (acc == ACC_MIN) begin
          decr_n = 1'b1;
          acc_n  = '0;
        end else begin
          acc_n = acc - 4'sd1;
        end
      end
      default: ;
    endcase
  end

  // Until primed, prev follows the same value loaded into phase,
  // so the reset-time encoder position is never seen as a step.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
      prev      <= '0;
      acc       <= '0;
      incr      <= 1'b0;
      decr      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
        primed    <= (prime_cnt == 2'd2);
        prev      <= {a_s, b_s};
      end else begin
        prev <= phase;
      end
      acc  <= acc_n;
      incr <= incr_n;
      decr <= decr_n;
      err  <= err_n;
    end
  end
endmodule

// File: tb/tb_quad_decoder_sfr.sv
// Scoreboard bench for quad_decoder_sfr: expected pulses are queued
// with their cycle stamps and matched against the observed pulses.

module tb_quad_decoder_sfr;
  localparam int DB  = 4;
  localparam int DV  = 4;
  localparam int LAT = DB + 3;

  localparam logic [1:0] K_INC = 2'd1;
  localparam logic [1:0] K_DEC = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic       a_in;
  logic       b_in;
  logic       incr;
  logic       decr;
  logic       err;
  logic [1:0] phase;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc   = 0;
  int  nvec  = 0;
  int  nerr  = 0;
  int  t_app = 0;

  quad_decoder_sfr #(.DB_CYCLES(DB), .DIV(DV)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (en),
    .a_in  (a_in),
    .b_in  (b_in),
    .incr  (incr),
    .decr  (decr),
    .err   (err),
    .phase (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (incr === 1'b1) obs_q.push_back(ev_t'{kind: K_INC, cyc: 32'(cyc)});
    if (decr === 1'b1) obs_q.push_back(ev_t'{kind: K_DEC, cyc: 32'(cyc)});
    if (err === 1'b1) obs_q.push_back(ev_t'{kind: K_ERR, cyc: 32'(cyc)});
  end

  function automatic logic [1:0] nxt_f(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_r(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] ab, input int hold);
    @(negedge clk);
    {a_in, b_in} = ab;
    t_app = cyc;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic steps(input bit f, input int n, input int hold);
    for (int i = 0; i < n; i++)
      drive(f ? nxt_f({a_in, b_in}) : nxt_r({a_in, b_in}), hold);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    clr_n = 1'b0;
    {a_in, b_in} = ab;
    idle(3);
    clr_n = 1'b1;
    idle(6);
  endtask

  task automatic push_exp(input logic [1:0] k);
    exp_q.push_back(ev_t'{kind: k, cyc: 32'(t_app + LAT)});
  endtask

  task automatic test_reset;
    ev_t o, e;
    clr_n = 1'b0;
    en = 1'b1;
    a_in = 1'b1;
    b_in = 1'b1;
    idle(4);
    nvec++;
    if ({incr, decr, err, phase} !== 5'b0) begin
      nerr++;
      $display("FAIL rst_outs: got %b, required 00000",
               {incr, decr, err, phase});
    end
    @(negedge clk) clr_n = 1'b1;
    idle(2);
    nvec++;
    if (phase !== 2'b00) begin
      nerr++;
      $display("FAIL prime_edge2: got %b, required 00", phase);
    end
    idle(1);
    nvec++;
    if (phase !== 2'b11) begin
      nerr++;
      $display("FAIL prime_edge3: got %b, required 11", phase);
    end
    idle(50);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL rst_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL rst_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_forward;
    ev_t o, e;
    do_reset(2'b00);
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    nvec++;
    if (phase !== 2'b00) begin
      nerr++;
      $display("FAIL fwd_phase: got %b, required 00", phase);
    end
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL fwd_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL fwd_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_jitter;
    ev_t o, e;
    steps(1'b0, 3, 10);
    steps(1'b1, 3, 10);
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL jit_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL jit_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reverse;
    ev_t o, e;
    steps(1'b0, 4, 10);
    push_exp(K_DEC);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL rev_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL rev_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch;
    ev_t o, e;
    bit moved;
    bit saw10;
    moved = 1'b0;
    saw10 = 1'b0;
    drive(2'b10, DB - 1);
    drive(2'b00, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (phase !== 2'b00) moved = 1'b1;
    end
    nvec++;
    if (moved) begin
      nerr++;
      $display("FAIL glitch_phase: got moved, required 00 held");
    end
    drive(2'b10, DB);
    drive(2'b00, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (phase === 2'b10) saw10 = 1'b1;
    end
    nvec++;
    if (!saw10) begin
      nerr++;
      $display("FAIL glitch_edge: got no 10, required phase 10 seen");
    end
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL gl_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL gl_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_jump;
    ev_t o, e;
    drive(2'b11, 10);
    push_exp(K_ERR);
    nvec++;
    if (phase !== 2'b11) begin
      nerr++;
      $display("FAIL jump_phase: got %b, required 11", phase);
    end
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL jmp_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL jmp_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_enable;
    ev_t o, e;
    @(negedge clk) en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(nxt_f({a_in, b_in}), 10);
      nvec++;
      if (phase !== {a_in, b_in}) begin
        nerr++;
        $display("FAIL en_track: got %b, required %b",
                 phase, {a_in, b_in});
      end
    end
    @(negedge clk) en = 1'b1;
    idle(20);
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    @(negedge clk) en = 1'b0;
    steps(1'b1, 2, 10);
    @(negedge clk) en = 1'b1;
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL en_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL en_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t o, e;
    for (int i = 0; i < 2 * DV; i++) begin
      drive(nxt_f({a_in, b_in}), DB + 1);
      if ((i % DV) == DV - 1) push_exp(K_INC);
    end
    idle(10);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL b2b_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL b2b_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_inflight;
    ev_t o, e;
    steps(1'b1, 3, 10);
    drive(nxt_f({a_in, b_in}), 1);
    idle(LAT - 1);
    clr_n = 1'b0;
    #1;
    nvec++;
    if ({incr, decr, err, phase} !== 5'b0) begin
      nerr++;
      $display("FAIL fly_rst: got %b, required 00000",
               {incr, decr, err, phase});
    end
    idle(2);
    clr_n = 1'b1;
    idle(10);
    nvec++;
    if (phase !== 2'b00) begin
      nerr++;
      $display("FAIL fly_phase: got %b, required 00", phase);
    end
    steps(1'b1, 4, 10);
    push_exp(K_INC);
    #1;
    nvec++;
    if (obs_q.size() !== exp_q.size()) begin
      nerr++;
      $display("FAIL fly_count: got %0d events, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++;
        $display("FAIL fly_event: got k%0d@%0d, required k%0d@%0d",
                 o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_forward;
    test_jitter;
    test_reverse;
    test_glitch;
    test_jump;
    test_enable;
    test_back_to_back;
    test_reset_inflight;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
